hex_display_ctrl: RTL and testbench
===================================

// Module: hex_display_ctrl
// PURPOSE
//  Avalon-MM slave driving NUM_DIGITS active-low seven-segment displays (DE-board HEXn).
//  Each digit is either a hex nibble decoded to segments or a raw 7-bit pattern, with
//  per-digit blanking and blinking from an internal prescaled blink timer.
//  Sits between the Nios/Avalon fabric and the board HEX pins; zero-wait-state reads.
// PARAMETERS
//  NUM_DIGITS    6         number of digits driven, 1..8
//  BLINK_DIV_RST 25000000  reset value of BLINK_DIV (half-period in clk cycles), 24 bits
// PORTS
//  clk         in   1              system clock
//  reset_n     in   1              asynchronous reset, active-low
//  address     in   4              word address
//  chipselect  in   1              slave select
//  write_n     in   1              write strobe, active-low
//  writedata   in   32             write data
//  readdata    out  32             read data, combinational from address
//  seg_out     out  NUM_DIGITS*7   segments, digit d at [7d+6:7d], bit0=seg a; 0=lit
// BEHAVIOUR
//  Register map (word addresses); write = chipselect & ~write_n; unmapped: read 0, write ignored
//   0 VALUE  RW  nibble per digit, digit d at [4d+3:4d]; reset 0
//   1 CTRL   RW  [7:0] decode_en (reset all 1), [15:8] blank (reset 0), [23:16] blink (reset 0)
//   2 BLINK_DIV RW [23:0]; reset BLINK_DIV_RST; [31:24] read 0
//   3 STATUS [0] blink_phase RO; [7:4] BRIGHT (see CONFIGURATION); others read 0
//   4+d RAW_d RW [6:0] raw active-low pattern for digit d < NUM_DIGITS; reset 7'h7F
//  Bits for digits >= NUM_DIGITS: write ignored, read 0.
//  Blink timer: 24-bit down-counter, reset = BLINK_DIV_RST, blink_phase reset 1 (visible).
//   - counter == 0 and BLINK_DIV != 0: reload BLINK_DIV, toggle blink_phase.
//   - else decrement. BLINK_DIV == 0: counter held 0, blink_phase forced 1.
//   - write to BLINK_DIV: counter loads new value, blink_phase set 1; write wins over
//     simultaneous expiry in the same cycle.
//  Per-digit pattern: pat = decode_en[d] ? hex7seg(VALUE nibble) : RAW_d;
//   off if blank[d] or (blink[d] & ~blink_phase); off = 7'h7F. blank overrides blink.
//  hex7seg: 0-F standard active-low (0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E).
//  seg_out registered: reflects register/phase state of previous cycle (1-cycle latency
//   after write accept). Reset value all ones (all segments off).
//  readdata: combinational mux of current register contents; no read strobe; no side effects.
//  Reset mid-operation: all registers, counter, phase and seg_out return to reset values
//   asynchronously; first post-reset clk edge shows "0" on every digit.
// CONFIGURATION
//  HEX_BRIGHTNESS_EN defined: STATUS[7:4] = BRIGHT RW, reset 4'hF; 4-bit free-running PWM
//   counter (reset 0); lit segments of all digits only driven low when pwm_cnt <= BRIGHT
//   (BRIGHT=15 always on, 0 = 1/16 duty); gating applied before seg_out register.
//  Not defined: STATUS[7:4] read 0, writes ignored, no PWM counter, segments never gated.
// STRUCTURE
//  Package hex_display_pkg: register address localparams (ADDR_VALUE..ADDR_RAW0),
//   CTRL field offsets, SEG_OFF = 7'h7F, 16-entry hex7seg constant table.
//  Sub-module hex7seg_decode: 4-bit nibble -> 7-bit active-low pattern, combinational,
//   instantiated NUM_DIGITS times by generate loop. Timer, regs, PWM stay in top.
// TESTING
//  1 reset, no writes -> seg_out = all ones during reset; 1 clk after release each digit = 7'h40
//  2 write VALUE=32'h00A5_F3C1 (NUM_DIGITS=6) -> digits 0..5 = 1,C,3,F,5,A; readback VALUE=32'h00A5F3C1
//  3 CTRL decode_en[2]=0, RAW_2=7'h36 -> digit2 = 7'h36 after 1 clk; RAW_7 write ignored, read 0
//  4 BLINK_DIV=4, blink[0]=1 -> digit0 alternates off/on every 5 clks; blank[0]=1 -> always 7'h7F
//  5 write BLINK_DIV in expiry cycle -> phase=1, counter=new value; BLINK_DIV=0 -> phase stuck 1
//  6 HEX_BRIGHTNESS_EN, BRIGHT=3 -> lit segments low 4 of every 16 clks; macro off -> STATUS[7:4]=0

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display controller: register map, CTRL field
// offsets, blank pattern and the active-low hex-to-segment lookup table.
package hex_display_pkg;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned DIV_W    = 24;
    localparam int unsigned BRIGHT_W = 4;

    localparam logic [ADDR_W-1:0] ADDR_VALUE     = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL      = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_DIV = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_RAW0      = 4'd4;

    localparam int unsigned CTRL_DECODE_LSB   = 0;
    localparam int unsigned CTRL_BLANK_LSB    = 8;
    localparam int unsigned CTRL_BLINK_LSB    = 16;
    localparam int unsigned STATUS_BRIGHT_LSB = 4;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Index n holds the active-low pattern for hex digit n (bit0 = segment a).
    localparam logic [15:0][SEG_W-1:0] HEX7SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_display_ctrl_hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = HEX7SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS active-low seven-segment displays with
// hex decode, raw patterns, blanking and blinking. Optional PWM brightness: HEX_BRIGHTNESS_EN.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned BLINK_DIV_RST = 25000000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ADDR_W-1:0]           address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [DATA_W-1:0]           writedata,
    output logic [DATA_W-1:0]           readdata,
    output logic [NUM_DIGITS*SEG_W-1:0] seg_out
);

    localparam int unsigned VAL_W  = NUM_DIGITS * 4;
    localparam int unsigned SEGS_W = NUM_DIGITS * SEG_W;
    // The timer is 24 bits wide; larger reset values keep their low 24 bits.
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(BLINK_DIV_RST);

    logic                             wr_c;
    logic                             div_wr_c;
    logic [VAL_W-1:0]                 value_q, value_d;
    logic [NUM_DIGITS-1:0]            decode_en_q, decode_en_d;
    logic [NUM_DIGITS-1:0]            blank_q, blank_d;
    logic [NUM_DIGITS-1:0]            blink_q, blink_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] raw_q, raw_d;
    logic [DIV_W-1:0]                 blink_div_q, blink_div_d;
    logic [DIV_W-1:0]                 cnt_q, cnt_d;
    logic                             phase_q, phase_d;
    logic [SEGS_W-1:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] dec_c;
    logic [BRIGHT_W-1:0]              bright_c;
    logic                             lit_en_c;
    logic                             unused_wdata_c;

`ifdef HEX_BRIGHTNESS_EN
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;

    assign bright_c = bright_q;
    assign lit_en_c = (pwm_q <= bright_q);
    assign pwm_d    = pwm_q + BRIGHT_W'(1);
`else
    assign bright_c = '0;
    assign lit_en_c = 1'b1;
`endif

    assign wr_c           = chipselect & ~write_n;
    assign div_wr_c       = wr_c && (address == ADDR_BLINK_DIV);
    // Upper writedata bits are ignored for narrow configurations.
    assign unused_wdata_c = ^writedata;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex7seg_decode u_dec (
            .nibble (value_q[4*g +: 4]),
            .seg_c  (dec_c[g])
        );
    end

    // Register file write decode
    always_comb begin
        value_d     = value_q;
        decode_en_d = decode_en_q;
        blank_d     = blank_q;
        blink_d     = blink_q;
        raw_d       = raw_q;
        blink_div_d = blink_div_q;
`ifdef HEX_BRIGHTNESS_EN
        bright_d    = bright_q;
`endif
        if (wr_c) begin
            case (address)
                ADDR_VALUE: value_d = writedata[VAL_W-1:0];
                ADDR_CTRL: begin
                    decode_en_d = writedata[CTRL_DECODE_LSB +: NUM_DIGITS];
                    blank_d     = writedata[CTRL_BLANK_LSB +: NUM_DIGITS];
                    blink_d     = writedata[CTRL_BLINK_LSB +: NUM_DIGITS];
                end
                ADDR_BLINK_DIV: blink_div_d = writedata[DIV_W-1:0];
`ifdef HEX_BRIGHTNESS_EN
                ADDR_STATUS: bright_d = writedata[STATUS_BRIGHT_LSB +: BRIGHT_W];
`endif
                default: begin
                    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                        if (address == ADDR_RAW0 + ADDR_W'(d)) begin
                            raw_d[d] = writedata[SEG_W-1:0];
                        end
                    end
                end
            endcase
        end
    end

    // Blink timer: a register write takes priority over expiry
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (div_wr_c) begin
            cnt_d   = writedata[DIV_W-1:0];
            phase_d = 1'b1;
        end else if (blink_div_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = blink_div_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Per-digit pattern select, blank/blink and brightness gating
    always_comb begin
        seg_d = '1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            seg_d[SEG_W*d +: SEG_W] = decode_en_q[d] ? dec_c[d] : raw_q[d];
            if (blank_q[d] || (blink_q[d] && !phase_q) || !lit_en_c) begin
                seg_d[SEG_W*d +: SEG_W] = SEG_OFF;
            end
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_VALUE: readdata = DATA_W'(value_q);
            ADDR_CTRL: begin
                readdata = (DATA_W'(blink_q) << CTRL_BLINK_LSB)
                         | (DATA_W'(blank_q) << CTRL_BLANK_LSB)
                         | (DATA_W'(decode_en_q) << CTRL_DECODE_LSB);
            end
            ADDR_BLINK_DIV: readdata = DATA_W'(blink_div_q);
            ADDR_STATUS: begin
                readdata = (DATA_W'(bright_c) << STATUS_BRIGHT_LSB) | DATA_W'(phase_q);
            end
            default: begin
                for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                    if (address == ADDR_RAW0 + ADDR_W'(d)) begin
                        readdata = DATA_W'(raw_q[d]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q     <= '0;
            decode_en_q <= '1;
            blank_q     <= '0;
            blink_q     <= '0;
            raw_q       <= {NUM_DIGITS{SEG_OFF}};
            blink_div_q <= DIV_RST;
            cnt_q       <= DIV_RST;
            phase_q     <= 1'b1;
            seg_q       <= '1;
`ifdef HEX_BRIGHTNESS_EN
            bright_q    <= '1;
            pwm_q       <= '0;
`endif
        end else begin
            value_q     <= value_d;
            decode_en_q <= decode_en_d;
            blank_q     <= blank_d;
            blink_q     <= blink_d;
            raw_q       <= raw_d;
            blink_div_q <= blink_div_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
`ifdef HEX_BRIGHTNESS_EN
            bright_q    <= bright_d;
            pwm_q       <= pwm_d;
`endif
        end
    end

    assign seg_out = seg_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: register vector table with a
// scoreboard queue, plus reset, blink timer and brightness sequences.
module tb_hex_display_ctrl;

    localparam int unsigned ND      = 6;
    localparam int unsigned DIV_RST = 50000;
    localparam logic [ND*7-1:0] ALL_OFF  = '1;
    localparam logic [ND*7-1:0] ALL_ZERO = {ND{7'h40}};

    logic            clk;
    logic            reset_n;
    logic [3:0]      address;
    logic            chipselect;
    logic            write_n;
    logic [31:0]     writedata;
    logic [31:0]     readdata;
    logic [ND*7-1:0] seg_out;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp_rd;
        int          d;
        logic [6:0]  exp_seg;
    } vec_t;

    typedef struct {
        string       name;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int          d;
        logic [6:0]  exp_seg;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];

    hex_display_ctrl #(
        .NUM_DIGITS    (ND),
        .BLINK_DIV_RST (DIV_RST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_out    (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dig(input int d);
        return seg_out[7*d +: 7];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] data);
        address    = a;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            if (e.chk_rd) check({e.name, "_rd"}, 64'(readdata), 64'(e.exp_rd));
            check({e.name, "_seg"}, 64'(dig(e.d)), 64'(e.exp_seg));
        end
    endtask

    initial begin
        exp_t        e;
        int          lit;
        logic [31:0] status_exp;
        logic        vis;

        vecs[0]  = '{1'b1, 4'd0,  32'h00A5_F3C1, 4'd0,  32'h00A5_F3C1, 0, 7'h79};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,         4'd1,  32'h0000_003F, 1, 7'h46};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,         4'd2,  32'(DIV_RST),  2, 7'h30};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,         4'd5,  32'h0000_007F, 3, 7'h0E};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,         4'd12, 32'h0,         4, 7'h12};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,         4'd3,  32'h0,         5, 7'h08};
        vecs[6]  = '{1'b1, 4'd6,  32'hFFFF_FFB6, 4'd6,  32'h0000_0036, 2, 7'h30};
        vecs[7]  = '{1'b1, 4'd1,  32'h0000_003B, 4'd1,  32'h0000_003B, 2, 7'h36};
        vecs[8]  = '{1'b1, 4'd11, 32'h0000_0055, 4'd11, 32'h0,         2, 7'h36};
        vecs[9]  = '{1'b1, 4'd1,  32'h0000_FF3F, 4'd1,  32'h0000_3F3F, 0, 7'h7F};
        vecs[10] = '{1'b1, 4'd1,  32'h0000_003F, 4'd1,  32'h0000_003F, 2, 7'h30};
        vecs[11] = '{1'b1, 4'd0,  32'hFFFF_FFFF, 4'd0,  32'h00FF_FFFF, 5, 7'h0E};
        vecs[12] = '{1'b1, 4'd0,  32'h00A5_F3C1, 4'd0,  32'h00A5_F3C1, 0, 7'h79};
        vecs[13] = '{1'b1, 4'd13, 32'hFFFF_FFFF, 4'd0,  32'h00A5_F3C1, 3, 7'h0E};
`ifdef HEX_BRIGHTNESS_EN
        vecs[5].exp_rd = 32'h0000_00F1;
`else
        vecs[5].exp_rd = 32'h0000_0001;
`endif

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 4'd0;
        writedata  = '0;

        // Power-on reset
        #23;
        check("rst_seg", 64'(seg_out), 64'(ALL_OFF));
        check("rst_value", 64'(readdata), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < int'(ND); d++) begin
            check($sformatf("post_rst_dig%0d", d), 64'(dig(d)), 64'h40);
        end

        // Register vector table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wdata);
            address = vecs[i].raddr;
            e = '{$sformatf("vec%0d", i), 1'b1, vecs[i].exp_rd, vecs[i].d, vecs[i].exp_seg};
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
            compare_next();
        end

        // Reset in the middle of operation
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        address = 4'd0;
        #1;
        check("mid_rst_seg", 64'(seg_out), 64'(ALL_OFF));
        check("mid_rst_value", 64'(readdata), 64'd0);
        address = 4'd1;
        #1;
        check("mid_rst_ctrl", 64'(readdata), 64'h3F);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_release", 64'(seg_out), 64'(ALL_ZERO));

        // Blink digit 0 with a 5-cycle half period
        bus_write(4'd0, 32'h00A5_F3C1);
        bus_write(4'd1, 32'h0001_003F);
        bus_write(4'd2, 32'd4);
        for (int k = 1; k <= 20; k++) begin
            vis = (((k - 1) / 5) % 2) == 0;
            e = '{$sformatf("blink%0d", k), 1'b0, 32'h0, 0, vis ? 7'h79 : 7'h7F};
            sb.push_back(e);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            compare_next();
        end

        // Blank overrides blink
        bus_write(4'd1, 32'h0001_013F);
        for (int k = 0; k < 12; k++) begin
            e = '{$sformatf("blank%0d", k), 1'b0, 32'h0, 0, 7'h7F};
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
            compare_next();
        end

        // BLINK_DIV write lands on the expiry edge
        bus_write(4'd2, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        bus_write(4'd2, 32'd3);
        address = 4'd3;
        #1;
        check("expiry_wr_phase", 64'(readdata[0]), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("reload_phase_hold", 64'(readdata[0]), 64'd1);
        @(posedge clk);
        #1;
        check("reload_phase_toggle", 64'(readdata[0]), 64'd0);

        // BLINK_DIV = 0 pins the phase visible
        bus_write(4'd2, 32'd0);
        #1;
        check("div0_readback", 64'(readdata), 64'd0);
        address = 4'd3;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("div0_phase%0d", k), 64'(readdata[0]), 64'd1);
        end

        // Brightness gating
        bus_write(4'd1, 32'h0000_003F);
        bus_write(4'd3, 32'h0000_0030);
        address = 4'd3;
        #1;
`ifdef HEX_BRIGHTNESS_EN
        status_exp = 32'h0000_0031;
`else
        status_exp = 32'h0000_0001;
`endif
        check("status_bright", 64'(readdata), 64'(status_exp));
        repeat (2) @(posedge clk);
        lit = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (dig(0) == 7'h79) lit++;
        end
`ifdef HEX_BRIGHTNESS_EN
        check("pwm_lit_cycles", 64'(lit), 64'd8);
`else
        check("pwm_lit_cycles", 64'(lit), 64'd32);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
